// File: rtl/lemming_hatch_ctrl.sv
// Hatch sequencer for the walker array: opens the hatch, releases lemmings one at a
// time over a valid/ready spawn handshake, and tallies saved/lost lemmings until done.
module lemming_hatch_ctrl #(
  parameter int unsigned NUM_LEM  = 8,
  parameter int unsigned GAP      = 4,
  parameter int unsigned OPEN_CYC = 3,
  parameter int unsigned CW       = $clog2(NUM_LEM + 1)
) (
  input  logic          clk,
  input  logic          areset_n,
  input  logic          start,
  input  logic          pause,
  input  logic          spawn_ready,
  input  logic          exit_pulse,
  input  logic          lost_pulse,
  output logic          spawn_valid,
  output logic          spawn_dir,
  output logic          hatch_open,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] released,
  output logic [CW-1:0] saved,
  output logic [CW-1:0] lost
);

  localparam int unsigned TMAX = (GAP > OPEN_CYC) ? GAP : OPEN_CYC;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned SW   = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OPENING,
    S_RELEASE,
    S_GAP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic          dir_q, dir_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] rel_q, rel_d;
  logic [CW-1:0] saved_q, saved_d;
  logic [CW-1:0] lost_q, lost_d;
  logic          counting_c;

  // State and counter registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      tmr_q   <= '0;
      rel_q   <= '0;
      saved_q <= '0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tmr_q   <= tmr_d;
      rel_q   <= rel_d;
      saved_q <= saved_d;
      lost_q  <= lost_d;
    end
  end

  // Next-state, timers and saturating tallies
  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    tmr_d      = tmr_q;
    rel_d      = rel_q;
    saved_d    = saved_q;
    lost_d     = lost_q;
    counting_c = (state_q != S_IDLE) && (state_q != S_DONE);

    if (counting_c) begin
      if (exit_pulse && (saved_q != CW'(NUM_LEM))) saved_d = saved_q + CW'(1);
      if (lost_pulse && (lost_q != CW'(NUM_LEM)))  lost_d  = lost_q + CW'(1);
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_OPENING;
          rel_d   = '0;
          saved_d = '0;
          lost_d  = '0;
          dir_d   = 1'b0;
          tmr_d   = TW'(OPEN_CYC - 1);
        end
      end
      S_OPENING, S_GAP: begin
        if (!pause) begin
          if (tmr_q == '0) state_d = S_RELEASE;
          else             tmr_d   = tmr_q - TW'(1);
        end
      end
      S_RELEASE: begin
        // valid stays up regardless of pause until the walker array takes it
        if (spawn_ready) begin
          rel_d = rel_q + CW'(1);
          dir_d = ~dir_q;
          if ((SW'(rel_q) + SW'(1)) == SW'(NUM_LEM)) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_GAP;
            tmr_d   = TW'(GAP - 1);
          end
        end
      end
      S_DRAIN: begin
        if ((SW'(saved_d) + SW'(lost_d)) == SW'(NUM_LEM)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign spawn_valid = (state_q == S_RELEASE);
  assign spawn_dir   = dir_q;
  assign hatch_open  = (state_q == S_OPENING) || (state_q == S_RELEASE) ||
                       (state_q == S_GAP)     || (state_q == S_DRAIN);
  assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign released    = rel_q;
  assign saved       = saved_q;
  assign lost        = lost_q;

endmodule
